// File: rtl/tdm_demux_1x16.sv
// Registered 1-to-16 demultiplexer with addressed and TDM (frame-rebuild) modes.
// Optional even-parity trailer bit on TDM frames when TDM_PARITY_EN is defined.
module tdm_demux_1x16 #(
  parameter int              NUM_CH    = 16,
  parameter logic [NUM_CH-1:0] RESET_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  input  logic              din,
  input  logic              din_valid,
  input  logic              sof,
  input  logic [3:0]        sel,
  output logic [NUM_CH-1:0] y,
  output logic [3:0]        ch_cnt,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

`ifdef TDM_PARITY_EN
  typedef enum logic [1:0] {IDLE, RUN, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t            state, state_n;
  logic [NUM_CH-1:0] shadow, shadow_n;
  logic [NUM_CH-1:0] y_n;
  logic [3:0]        cnt_n;
  logic              done_n, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      y          <= RESET_VAL;
      ch_cnt     <= 4'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      y          <= y_n;
      ch_cnt     <= cnt_n;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

  // Any non-IDLE state in addressed mode means the mode just flipped mid-frame.
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    y_n      = y;
    cnt_n    = ch_cnt;
    done_n   = 1'b0;
    err_n    = 1'b0;

    if (!enable) begin
      y_n     = RESET_VAL;
      cnt_n   = 4'd0;
      state_n = IDLE;
    end else if (!mode) begin
      if (state != IDLE) begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
      if (din_valid)
        y_n[sel] = din;
    end else if (din_valid) begin
      case (state)
        IDLE: begin
          if (sof) begin
            shadow_n[0] = din;
            cnt_n       = 4'd1;
            state_n     = RUN;
          end
        end
        RUN: begin
          if (sof) begin
            err_n       = 1'b1;
            shadow_n[0] = din;
            cnt_n       = 4'd1;
          end else begin
            shadow_n[ch_cnt] = din;
            cnt_n            = ch_cnt + 4'd1;
            if (ch_cnt == LAST_CH) begin
`ifdef TDM_PARITY_EN
              state_n = PAR;
`else
              y_n     = {din, shadow[NUM_CH-2:0]};
              done_n  = 1'b1;
              cnt_n   = 4'd0;
              state_n = IDLE;
`endif
            end
          end
        end
`ifdef TDM_PARITY_EN
        PAR: begin
          if (sof) begin
            err_n       = 1'b1;
            shadow_n[0] = din;
            cnt_n       = 4'd1;
            state_n     = RUN;
          end else begin
            if (din == ^shadow) begin
              y_n    = shadow;
              done_n = 1'b1;
            end else begin
              err_n  = 1'b1;
            end
            cnt_n   = 4'd0;
            state_n = IDLE;
          end
        end
`endif
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

endmodule
